// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RV32 core.
//
// Resolves E-stage operand forwarding, load-use stalls, taken-branch/jump
// flushes and multi-cycle data-memory waits. A memory access that stays
// not-ready for MEM_TIMEOUT consecutive cycles parks the controller in a
// sticky FAULT state (pipeline frozen) until reset.
//
// Ports:
//   clk, rst                      core clock, asynchronous active-low reset
//   rs1_d, rs2_d                  source registers of the D instruction
//   rs1_e, rs2_e, rd_e            source/destination registers of the E instruction
//   rd_m, rd_w                    destination registers of the M / W instructions
//   resultsrc_e                   E result select (2'b01 = load)
//   regwrite_m, regwrite_w        M / W instructions write the register file
//   pcsrc_e                       taken branch or jump resolved in E
//   mem_req_m, mem_ready          data-memory handshake for the M access
//   forward_a_e, forward_b_e      E operand select: 00 rd, 10 M ALU result, 01 W result
//   stall_f, stall_d, stall_e,
//   stall_m                       hold PC, F/D, D/E, E/M registers
//   flush_d, flush_e, flush_w     clear F/D, D/E, M/W registers
//   mem_fault                     sticky memory-timeout flag
//
// Optional build macro HAZARD_PERF_EN adds 32-bit wrapping event counters
// perf_lw_stalls, perf_flushes and perf_mem_waits as output ports.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic [1:0] resultsrc_e,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    input  logic       pcsrc_e,
    input  logic       mem_req_m,
    input  logic       mem_ready,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       flush_d,
    output logic       stall_e,
    output logic       flush_e,
    output logic       stall_m,
    output logic       flush_w,
`ifdef HAZARD_PERF_EN
    output logic [31:0] perf_lw_stalls,
    output logic [31:0] perf_flushes,
    output logic [31:0] perf_mem_waits,
`endif
    output logic       mem_fault
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    logic lw_stall;
    logic mem_stall;
    logic freeze;

    // Forwarding: M stage has priority over W; x0 is never forwarded.
    always_comb begin
        forward_a_e = 2'b00;
        if (regwrite_m && rd_m != 5'd0 && rd_m == rs1_e)
            forward_a_e = 2'b10;
        else if (regwrite_w && rd_w != 5'd0 && rd_w == rs1_e)
            forward_a_e = 2'b01;
    end

    always_comb begin
        forward_b_e = 2'b00;
        if (regwrite_m && rd_m != 5'd0 && rd_m == rs2_e)
            forward_b_e = 2'b10;
        else if (regwrite_w && rd_w != 5'd0 && rd_w == rs2_e)
            forward_b_e = 2'b01;
    end

    assign lw_stall  = (resultsrc_e == 2'b01) && (rd_e != 5'd0) &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mem_stall = mem_req_m && !mem_ready;

    // Freeze is decoded from the current state and live inputs so it takes
    // effect in the very cycle the memory first reports not-ready. The
    // mem_ready cycle in MEM_WAIT falls through to the normal RUN equations.
    always_comb begin
        unique case (state)
            RUN:      freeze = mem_stall;
            MEM_WAIT: freeze = !mem_ready;
            default:  freeze = 1'b1;
        endcase
    end

    // While frozen, lw_stall/pcsrc_e are masked; the held E instruction
    // presents them again once the pipeline is released.
    always_comb begin
        if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end else begin
            stall_f = lw_stall;
            stall_d = lw_stall;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_w = 1'b0;
            flush_d = pcsrc_e;
            flush_e = lw_stall || pcsrc_e;
        end
    end

    // wait_cnt holds the number of stalled cycles already spent on the
    // current access, so the FAULT decision lands on stalled cycle MEM_TIMEOUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_fault <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                        state     <= FAULT;
                        mem_fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= FAULT;
                    mem_fault <= 1'b1;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    // Memory-wait cycles are the frozen cycles outside the terminal FAULT state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_lw_stalls <= '0;
            perf_flushes   <= '0;
            perf_mem_waits <= '0;
        end else begin
            if (!freeze && lw_stall)
                perf_lw_stalls <= perf_lw_stalls + 32'd1;
            if (!freeze && pcsrc_e)
                perf_flushes <= perf_flushes + 32'd1;
            if (freeze && state != FAULT)
                perf_mem_waits <= perf_mem_waits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned MT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
    logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
    logic [1:0] resultsrc_e = '0;
    logic       regwrite_m = 1'b0, regwrite_w = 1'b0, pcsrc_e = 1'b0;
    logic       mem_req_m = 1'b0, mem_ready = 1'b0;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;
    logic       mem_fault;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: stalled cycles spent on the current access
    // (0 = no access pending) and the sticky fault.
    int unsigned m_stalled = 0;
    bit          m_fault   = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .resultsrc_e(resultsrc_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .pcsrc_e(pcsrc_e), .mem_req_m(mem_req_m), .mem_ready(mem_ready),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .stall_e(stall_e), .flush_e(flush_e), .stall_m(stall_m),
        .flush_w(flush_w), .mem_fault(mem_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (regwrite_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (regwrite_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    // Expected {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w, mem_fault}
    function automatic logic [7:0] ref_ctl();
        bit lw, frz;
        lw  = (resultsrc_e == 2'b01) && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        frz = m_fault || (m_stalled > 0 && !mem_ready) ||
              (m_stalled == 0 && mem_req_m && !mem_ready);
        if (frz) return {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, m_fault};
        return {lw, lw, pcsrc_e, 1'b0, lw | pcsrc_e, 1'b0, 1'b0, m_fault};
    endfunction

    function automatic logic [7:0] dut_ctl();
        return {stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w, mem_fault};
    endfunction

    task automatic model_clock();
        if (m_fault) return;
        if (m_stalled > 0) begin
            if (mem_ready) m_stalled = 0;
            else begin
                m_stalled++;
                if (m_stalled == MT) m_fault = 1'b1;
            end
        end else if (mem_req_m && !mem_ready) begin
            m_stalled = 1;
        end
    endtask

    // Inputs are applied just after the falling edge, outputs sampled 1 ns
    // later, and the model advances at the following rising edge.
    task automatic step(input string tag);
        #1;
        check({tag, "_fwd_a"}, 32'(forward_a_e), 32'(ref_fwd(rs1_e)));
        check({tag, "_fwd_b"}, 32'(forward_b_e), 32'(ref_fwd(rs2_e)));
        check({tag, "_ctl"}, 32'(dut_ctl()), 32'(ref_ctl()));
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0; resultsrc_e = '0;
        regwrite_m = 0; regwrite_w = 0; pcsrc_e = 0; mem_req_m = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        m_stalled = 0;
        m_fault   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic randomize_inputs();
        rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
        rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
        rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
        rd_w  = 5'($urandom_range(0, 3));
        resultsrc_e = 2'($urandom_range(0, 3));
        regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
        pcsrc_e   = ($urandom_range(0, 3) == 0);
        mem_req_m = ($urandom_range(0, 2) == 0);
        mem_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        do_reset();
        @(negedge clk);

        // Reset state with all inputs low: everything zero.
        #1;
        check("reset_ctl", 32'(dut_ctl()), 32'h0);
        check("reset_fwd", 32'({forward_a_e, forward_b_e}), 32'h0);
        @(negedge clk);

        // Forwarding, M over W, then W only.
        rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs1_e = 5; rs2_e = 0;
        #1;
        check("fwd_m_pri", 32'(forward_a_e), 32'h2);
        check("fwd_b_x0", 32'(forward_b_e), 32'h0);
        regwrite_m = 0;
        #1;
        check("fwd_w", 32'(forward_a_e), 32'h1);
        clear_inputs();
        @(negedge clk);

        // Load-use hit and the rd_e==0 exemption.
        resultsrc_e = 2'b01; rd_e = 7; rs2_d = 7;
        step("lw_hit");
        rd_e = 0;
        step("lw_x0");
        clear_inputs();

        // Branch flush.
        pcsrc_e = 1;
        step("branch");
        pcsrc_e = 0;
        step("branch_after");

        // Three not-ready cycles with a pending branch, then release.
        mem_req_m = 1; mem_ready = 0; pcsrc_e = 1;
        for (int unsigned i = 0; i < 3; i++) step("memwait");
        mem_ready = 1;
        #1;
        check("mem_release_flush_d", 32'(flush_d), 32'h1);
        check("mem_release_stall_m", 32'(stall_m), 32'h0);
        step("memrel");
        clear_inputs();

        // Timeout: four stalled cycles, then sticky fault.
        mem_req_m = 1; mem_ready = 0;
        for (int unsigned i = 0; i < MT + 2; i++) step("timeout");
        #1;
        check("fault_sticky", 32'(mem_fault), 32'h1);
        check("fault_freeze", 32'(stall_f & flush_w), 32'h1);
        mem_ready = 1; mem_req_m = 0;
        step("fault_ignores_ready");

        // Asynchronous reset in the middle of a cycle while faulted.
        clear_inputs();
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_ctl", 32'(dut_ctl()), 32'h0);
        m_stalled = 0;
        m_fault   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Randomized traffic against the model; reset occasionally to leave FAULT.
        for (int unsigned n = 0; n < 3000; n++) begin
            if (m_fault && $urandom_range(0, 3) == 0) begin
                do_reset();
                @(negedge clk);
            end
            randomize_inputs();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
